// File: rtl/la_capture_ctrl_if.sv
// Register-file side of the logic-analyzer capture sequencer: control, latched config and status.
// Optional trigger timeout signals exist only when LA_TRIG_TIMEOUT_EN is defined.
interface la_capture_ctrl_if #(
  parameter int LA_WIDTH    = 8,
  parameter int COUNT_WIDTH = 23
);
  logic                   start;
  logic                   abort;
  logic [COUNT_WIDTH-1:0] samples_post;
  logic [LA_WIDTH-1:0]    trig_mask;
  logic [LA_WIDTH-1:0]    trig_pattern;
  logic                   trig_edge;
  logic [1:0]             state;
  logic [COUNT_WIDTH-1:0] pre_count;
  logic [COUNT_WIDTH-1:0] post_count;
  logic                   done;
`ifdef LA_TRIG_TIMEOUT_EN
  logic [COUNT_WIDTH-1:0] trig_timeout;
  logic                   timed_out;
`endif

  modport master (
    output start, abort, samples_post, trig_mask, trig_pattern, trig_edge,
`ifdef LA_TRIG_TIMEOUT_EN
    output trig_timeout,
    input  timed_out,
`endif
    input  state, pre_count, post_count, done
  );

  modport slave (
    input  start, abort, samples_post, trig_mask, trig_pattern, trig_edge,
`ifdef LA_TRIG_TIMEOUT_EN
    input  trig_timeout,
    output timed_out,
`endif
    output state, pre_count, post_count, done
  );
endinterface

// File: rtl/la_capture_ctrl.sv
// Logic-analyzer capture sequencer: arms SRAM buffers, matches a masked level/edge trigger,
// counts post-trigger samples, then gates the SRAM clock off. Optional: LA_TRIG_TIMEOUT_EN.
module la_capture_ctrl #(
  parameter int LA_WIDTH    = 8,
  parameter int LA_CHIPS    = 2,
  parameter int COUNT_WIDTH = 23
) (
  input  logic                clock,
  input  logic                reset_n,
  la_capture_ctrl_if.slave    ctrl,
  input  logic [LA_WIDTH-1:0] la_in,
  output logic                sram_clk_en,
  output logic [LA_CHIPS-1:0] sram_cs_n
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] pre_q, pre_d, pre_inc;
  logic [COUNT_WIDTH-1:0] post_q, post_d;
  logic [COUNT_WIDTH-1:0] post_l;
  logic [LA_WIDTH-1:0]    mask_l, pat_l, la_prev;
  logic                   edge_l, first_q, done_q, load;
  logic                   match, match_prev, trigger, post_hit;
  logic                   capture_d;
`ifdef LA_TRIG_TIMEOUT_EN
  logic [COUNT_WIDTH-1:0] to_l;
  logic                   timed_q, timed_d;
`endif

  assign match      = ((la_in ^ pat_l) & mask_l) == '0;
  // The first ARMED cycle has no valid history, so it behaves as if the channel already matched.
  assign match_prev = first_q | (((la_prev ^ pat_l) & mask_l) == '0);
  assign trigger    = edge_l ? (match & ~match_prev) : match;
  assign pre_inc    = (&pre_q) ? pre_q : pre_q + COUNT_WIDTH'(1);
  // Compare one bit wider so post_l = all-ones cannot alias with a wrapped target.
  assign post_hit   = ((COUNT_WIDTH+1)'(post_q)) == ((COUNT_WIDTH+1)'(post_l) + (COUNT_WIDTH+1)'(1));

  // NOTE: every variable driven here gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    post_d  = post_q;
    load    = 1'b0;
`ifdef LA_TRIG_TIMEOUT_EN
    timed_d = timed_q;
`endif
    if (ctrl.abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (ctrl.start) begin
            state_d = ARMED;
            load    = 1'b1;
            pre_d   = '0;
            post_d  = '0;
`ifdef LA_TRIG_TIMEOUT_EN
            timed_d = 1'b0;
`endif
          end
        end
        ARMED: begin
          pre_d = pre_inc;
          if (trigger) begin
            state_d = POST;
            post_d  = COUNT_WIDTH'(1);
          end
`ifdef LA_TRIG_TIMEOUT_EN
          else if (to_l != '0 && pre_inc == to_l) begin
            state_d = POST;
            post_d  = COUNT_WIDTH'(1);
            timed_d = 1'b1;
          end
`endif
        end
        POST: begin
          if (post_hit) state_d = DONE;
          else if (!(&post_q)) post_d = post_q + COUNT_WIDTH'(1);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign capture_d = (state_d == ARMED) || (state_d == POST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pre_q       <= '0;
      post_q      <= '0;
      post_l      <= '0;
      mask_l      <= '0;
      pat_l       <= '0;
      edge_l      <= 1'b0;
      la_prev     <= '0;
      first_q     <= 1'b0;
      done_q      <= 1'b0;
      sram_clk_en <= 1'b0;
      sram_cs_n   <= '1;
`ifdef LA_TRIG_TIMEOUT_EN
      to_l        <= '0;
      timed_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pre_q       <= pre_d;
      post_q      <= post_d;
      la_prev     <= load ? '0 : la_in;
      first_q     <= load;
      done_q      <= (state_d == DONE);
      sram_clk_en <= capture_d;
      sram_cs_n   <= {LA_CHIPS{~capture_d}};
`ifdef LA_TRIG_TIMEOUT_EN
      timed_q     <= timed_d;
`endif
      if (load) begin
        post_l <= ctrl.samples_post;
        mask_l <= ctrl.trig_mask;
        pat_l  <= ctrl.trig_pattern;
        edge_l <= ctrl.trig_edge;
`ifdef LA_TRIG_TIMEOUT_EN
        to_l   <= ctrl.trig_timeout;
`endif
      end
    end
  end

  assign ctrl.state      = state_q;
  assign ctrl.pre_count  = pre_q;
  assign ctrl.post_count = post_q;
  assign ctrl.done       = done_q;
`ifdef LA_TRIG_TIMEOUT_EN
  assign ctrl.timed_out  = timed_q;
`endif

endmodule

// File: tb/tb_la_capture_ctrl.sv
// Directed bench for la_capture_ctrl: reset, level/edge/zero-mask triggers, abort races,
// mid-capture reset and (with LA_TRIG_TIMEOUT_EN) the trigger timeout.
module tb_la_capture_ctrl;
  localparam int LA_WIDTH    = 8;
  localparam int LA_CHIPS    = 2;
  localparam int COUNT_WIDTH = 23;

  logic                clock = 1'b0;
  logic                reset_n = 1'b0;
  logic [LA_WIDTH-1:0] la_in = '0;
  logic                sram_clk_en;
  logic [LA_CHIPS-1:0] sram_cs_n;
  int                  tests_run = 0;
  int                  fails = 0;

  la_capture_ctrl_if #(.LA_WIDTH(LA_WIDTH), .COUNT_WIDTH(COUNT_WIDTH)) ctrl ();

  la_capture_ctrl #(.LA_WIDTH(LA_WIDTH), .LA_CHIPS(LA_CHIPS), .COUNT_WIDTH(COUNT_WIDTH)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .ctrl        (ctrl),
    .la_in       (la_in),
    .sram_clk_en (sram_clk_en),
    .sram_cs_n   (sram_cs_n)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    ctrl.start = 1'b0; ctrl.abort = 1'b0; ctrl.samples_post = '0;
    ctrl.trig_mask = '0; ctrl.trig_pattern = '0; ctrl.trig_edge = 1'b0;
`ifdef LA_TRIG_TIMEOUT_EN
    ctrl.trig_timeout = '0;
`endif
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    tests_run++; if (ctrl.state !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", ctrl.state); end
    tests_run++; if (sram_cs_n !== 2'b11) begin fails++; $display("FAIL reset_cs_n: got %b want 11", sram_cs_n); end
    tests_run++; if (sram_clk_en !== 1'b0) begin fails++; $display("FAIL reset_clk_en: got %b want 0", sram_clk_en); end
    tests_run++; if (ctrl.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", ctrl.done); end
    tests_run++; if (ctrl.pre_count !== '0 || ctrl.post_count !== '0) begin fails++;
      $display("FAIL reset_counts: got pre %0d post %0d want 0 0", ctrl.pre_count, ctrl.post_count); end
  endtask

  task automatic test_level();
    int n_post;
    ctrl.trig_mask = 8'h0F; ctrl.trig_pattern = 8'h05; ctrl.trig_edge = 1'b0;
    ctrl.samples_post = 23'd3; la_in = 8'h00; ctrl.start = 1'b1;
    tick();
    ctrl.start = 1'b0;
    ctrl.trig_pattern = 8'hFF;  // must be ignored: latched value stays 05
    tests_run++; if (ctrl.state !== 2'd1 || ctrl.pre_count !== 23'd0) begin fails++;
      $display("FAIL level_armed: got state %0d pre %0d want 1 0", ctrl.state, ctrl.pre_count); end
    tests_run++; if (sram_clk_en !== 1'b1 || sram_cs_n !== 2'b00) begin fails++;
      $display("FAIL level_sram_on: got en %b cs_n %b want 1 00", sram_clk_en, sram_cs_n); end
    for (int i = 1; i <= 9; i++) begin
      ctrl.start = (i == 4);  // re-arm attempt while ARMED is ignored
      tick();
    end
    ctrl.start = 1'b0;
    tests_run++; if (ctrl.state !== 2'd1 || ctrl.pre_count !== 23'd9) begin fails++;
      $display("FAIL level_waiting: got state %0d pre %0d want 1 9", ctrl.state, ctrl.pre_count); end
    la_in = 8'hA5;
    tick();
    la_in = 8'h00;
    tests_run++; if (ctrl.state !== 2'd2 || ctrl.pre_count !== 23'd10 || ctrl.post_count !== 23'd1) begin fails++;
      $display("FAIL level_trigger: got state %0d pre %0d post %0d want 2 10 1", ctrl.state, ctrl.pre_count, ctrl.post_count); end
    n_post = 1;
    for (int k = 0; k < 20 && ctrl.state == 2'd2; k++) begin
      tick();
      if (ctrl.state == 2'd2) n_post++;
    end
    tests_run++; if (n_post !== 4) begin fails++; $display("FAIL level_post_cycles: got %0d want 4", n_post); end
    tests_run++; if (ctrl.state !== 2'd3 || ctrl.done !== 1'b1) begin fails++;
      $display("FAIL level_done: got state %0d done %b want 3 1", ctrl.state, ctrl.done); end
    tests_run++; if (sram_clk_en !== 1'b0 || sram_cs_n !== 2'b11) begin fails++;
      $display("FAIL level_sram_off: got en %b cs_n %b want 0 11", sram_clk_en, sram_cs_n); end
    tests_run++; if (ctrl.post_count !== 23'd4 || ctrl.pre_count !== 23'd10) begin fails++;
      $display("FAIL level_counts: got pre %0d post %0d want 10 4", ctrl.pre_count, ctrl.post_count); end
  endtask

  task automatic test_zero_mask();
    ctrl.trig_mask = 8'h00; ctrl.trig_pattern = 8'h3C; ctrl.samples_post = 23'd0;
    la_in = 8'h81; ctrl.start = 1'b1;
    tick();
    ctrl.start = 1'b0;
    tests_run++; if (ctrl.state !== 2'd1 || ctrl.pre_count !== 23'd0 || ctrl.post_count !== 23'd0 || ctrl.done !== 1'b0) begin fails++;
      $display("FAIL zero_restart: got state %0d pre %0d post %0d done %b want 1 0 0 0",
               ctrl.state, ctrl.pre_count, ctrl.post_count, ctrl.done); end
    tick();
    tests_run++; if (ctrl.state !== 2'd2 || ctrl.pre_count !== 23'd1 || ctrl.post_count !== 23'd1) begin fails++;
      $display("FAIL zero_post: got state %0d pre %0d post %0d want 2 1 1", ctrl.state, ctrl.pre_count, ctrl.post_count); end
    tick();
    tests_run++; if (ctrl.state !== 2'd3 || ctrl.post_count !== 23'd1 || ctrl.done !== 1'b1) begin fails++;
      $display("FAIL zero_done: got state %0d post %0d done %b want 3 1 1", ctrl.state, ctrl.post_count, ctrl.done); end
  endtask

  task automatic test_edge();
    ctrl.trig_mask = 8'h01; ctrl.trig_pattern = 8'h01; ctrl.trig_edge = 1'b1;
    ctrl.samples_post = 23'd1; la_in = 8'h01; ctrl.start = 1'b1;
    tick();
    ctrl.start = 1'b0;
    repeat (3) tick();
    tests_run++; if (ctrl.state !== 2'd1 || ctrl.pre_count !== 23'd3) begin fails++;
      $display("FAIL edge_no_initial: got state %0d pre %0d want 1 3", ctrl.state, ctrl.pre_count); end
    la_in = 8'h00;
    tick();
    tests_run++; if (ctrl.state !== 2'd1) begin fails++; $display("FAIL edge_low: got state %0d want 1", ctrl.state); end
    la_in = 8'h01;
    tick();
    tests_run++; if (ctrl.state !== 2'd2 || ctrl.pre_count !== 23'd5 || ctrl.post_count !== 23'd1) begin fails++;
      $display("FAIL edge_rise: got state %0d pre %0d post %0d want 2 5 1", ctrl.state, ctrl.pre_count, ctrl.post_count); end
    repeat (2) tick();
    tests_run++; if (ctrl.state !== 2'd3 || ctrl.post_count !== 23'd2) begin fails++;
      $display("FAIL edge_done: got state %0d post %0d want 3 2", ctrl.state, ctrl.post_count); end
    ctrl.trig_edge = 1'b0;
  endtask

  task automatic test_abort_race();
    ctrl.abort = 1'b1;
    tick();
    ctrl.abort = 1'b0;
    tests_run++; if (ctrl.state !== 2'd0 || ctrl.done !== 1'b0 || ctrl.post_count !== 23'd2) begin fails++;
      $display("FAIL abort_done: got state %0d done %b post %0d want 0 0 2", ctrl.state, ctrl.done, ctrl.post_count); end
    ctrl.start = 1'b1; ctrl.abort = 1'b1;
    tick();
    ctrl.start = 1'b0; ctrl.abort = 1'b0;
    tests_run++; if (ctrl.state !== 2'd0 || sram_clk_en !== 1'b0) begin fails++;
      $display("FAIL abort_wins: got state %0d en %b want 0 0", ctrl.state, sram_clk_en); end
    ctrl.trig_mask = 8'h00; ctrl.samples_post = 23'd10; ctrl.start = 1'b1;
    tick();
    ctrl.start = 1'b0;
    repeat (2) tick();
    ctrl.abort = 1'b1;
    tick();
    ctrl.abort = 1'b0;
    tests_run++; if (ctrl.state !== 2'd0 || ctrl.done !== 1'b0) begin fails++;
      $display("FAIL abort_post_state: got state %0d done %b want 0 0", ctrl.state, ctrl.done); end
    tests_run++; if (ctrl.pre_count !== 23'd1 || ctrl.post_count !== 23'd2) begin fails++;
      $display("FAIL abort_post_hold: got pre %0d post %0d want 1 2", ctrl.pre_count, ctrl.post_count); end
    tests_run++; if (sram_clk_en !== 1'b0 || sram_cs_n !== 2'b11) begin fails++;
      $display("FAIL abort_post_sram: got en %b cs_n %b want 0 11", sram_clk_en, sram_cs_n); end
  endtask

  task automatic test_reset_mid();
    ctrl.trig_mask = 8'hFF; ctrl.trig_pattern = 8'hFF; la_in = 8'h00; ctrl.start = 1'b1;
    tick();
    ctrl.start = 1'b0;
    repeat (2) tick();
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    tests_run++; if (sram_clk_en !== 1'b0 || sram_cs_n !== 2'b11 || ctrl.state !== 2'd0 || ctrl.pre_count !== '0) begin fails++;
      $display("FAIL reset_mid: got en %b cs_n %b state %0d pre %0d want 0 11 0 0",
               sram_clk_en, sram_cs_n, ctrl.state, ctrl.pre_count); end
    @(negedge clock);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_timeout();
`ifdef LA_TRIG_TIMEOUT_EN
    ctrl.trig_mask = 8'hFF; ctrl.trig_pattern = 8'hFF; la_in = 8'h00;
    ctrl.samples_post = 23'd5; ctrl.trig_timeout = 23'd20; ctrl.start = 1'b1;
    tick();
    ctrl.start = 1'b0;
    for (int k = 0; k < 100 && ctrl.state == 2'd1; k++) tick();
    tests_run++; if (ctrl.state !== 2'd2 || ctrl.pre_count !== 23'd20 || ctrl.post_count !== 23'd1) begin fails++;
      $display("FAIL timeout_fire: got state %0d pre %0d post %0d want 2 20 1", ctrl.state, ctrl.pre_count, ctrl.post_count); end
    tests_run++; if (ctrl.timed_out !== 1'b1) begin fails++; $display("FAIL timeout_flag: got %b want 1", ctrl.timed_out); end
    ctrl.abort = 1'b1;
    tick();
    ctrl.abort = 1'b0;
    ctrl.start = 1'b1;
    tick();
    ctrl.start = 1'b0;
    tests_run++; if (ctrl.timed_out !== 1'b0) begin fails++; $display("FAIL timeout_clear: got %b want 0", ctrl.timed_out); end
    ctrl.trig_timeout = '0;
`else
    ctrl.trig_mask = 8'hFF; ctrl.trig_pattern = 8'hFF; la_in = 8'h00; ctrl.start = 1'b1;
    tick();
    ctrl.start = 1'b0;
    repeat (100) tick();
    tests_run++; if (ctrl.state !== 2'd1 || ctrl.pre_count !== 23'd100) begin fails++;
      $display("FAIL no_timeout: got state %0d pre %0d want 1 100", ctrl.state, ctrl.pre_count); end
`endif
    ctrl.abort = 1'b1;
    tick();
    ctrl.abort = 1'b0;
  endtask

  initial begin
    test_reset();
    test_level();
    test_zero_mask();
    test_edge();
    test_abort_race();
    test_reset_mid();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/la_capture_ctrl.md
Name: la_capture_ctrl

Overview:
Parametrised logic-analyzer capture sequencer that replaces the fixed start/la_done/sample_counter logic in the top level. It arms the SRAM sample buffers and matches a masked level or edge trigger on the LA inputs. After the trigger it counts a programmable number of post-trigger samples, then stops SRAM clocking and reports status. It sits between the memory-controller register file (control/config registers) and the sram_clock/sram_cs muxing for LA_CHIPS SRAMs.

Parameters:
LA_WIDTH, 8, number of LA input channels.
LA_CHIPS, 2, number of SRAM chips, driven in parallel.
COUNT_WIDTH, 23, width of the sample counters and of samples_post.

Ports:
clock  in  1  system clock; all logic on rising edge.
reset_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle arm request.
abort  in  1  one-cycle abort request.
samples_post  in  COUNT_WIDTH  post-trigger sample count; latched on accepted start.
trig_mask  in  LA_WIDTH  1 = channel participates in trigger; latched on start.
trig_pattern  in  LA_WIDTH  required level per masked channel; latched on start.
trig_edge  in  1  0 = level trigger, 1 = edge trigger; latched on start.
la_in  in  LA_WIDTH  already-synchronised LA sample, one per clock.
sram_clk_en  out  1  gate for the SRAM clock source (clock passes when high).
sram_cs_n  out  LA_CHIPS  SRAM chip selects, active low.
state  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE.
pre_count  out  COUNT_WIDTH  samples taken before the trigger; saturating.
post_count  out  COUNT_WIDTH  samples taken since the trigger.
done  out  1  high while in DONE.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, sram_clk_en=0, sram_cs_n=all 1, pre_count=0, post_count=0, done=0, latched config=0, la_prev=0.
- Registered outputs: sram_clk_en=1 and sram_cs_n=all 0 exactly while state is ARMED or POST.
- match = ((la_in ^ pat_l) & mask_l)==0.
- trigger:
  - Level mode: trigger = match.
  - Edge mode: trigger = match && !match_prev. match_prev is computed from la_prev, the previous cycle's la_in; la_prev is cleared on entry to ARMED.
- IDLE or DONE + start -> ARMED next cycle. Entry clears pre_count, post_count and done, and latches all config.
- ARMED:
  - pre_count increments each cycle, saturating at all-ones.
  - A trigger this cycle -> POST. The trigger sample counts as post sample 1 (post_count=1).
  - mask_l=0 gives an immediate trigger on the first ARMED cycle.
  - In edge mode the first ARMED cycle cannot trigger when it already matches, because match_prev is forced to 1 on entry.
- POST:
  - post_count increments each cycle.
  - When post_count==post_l+1 -> DONE. Total post samples = samples_post+1, including the trigger sample. samples_post=0 gives 1 sample.
  - post_count never wraps: post_l+1 is computed at COUNT_WIDTH+1 bits.
- DONE: holds all counters; done=1; waits for start.
- abort in any state -> IDLE next cycle. Counters hold for readback; done=0.
- start and abort in the same cycle: abort wins.
- start while ARMED/POST: ignored.
- Config inputs changing mid-capture: no effect (latched values are used).
- reset_n asserted mid-capture: immediate return to reset values; SRAM clock gating drops asynchronously.

Optional Feature:
LA_TRIG_TIMEOUT_EN
- Defined: adds input trig_timeout [COUNT_WIDTH-1:0] (latched on start) and output timed_out (1).
  - In ARMED, when pre_count reaches trig_timeout with no trigger, the block forces the trigger: -> POST with timed_out=1.
  - trig_timeout=0 disables the timeout.
  - timed_out clears on the next accepted start and on reset.
  - A real trigger in the same cycle as the timeout takes precedence: timed_out=0.
- Undefined: neither port exists; ARMED waits indefinitely.

Test Plan:
- Reset check: reset_n low, then release -> state=0, sram_cs_n=2'b11, sram_clk_en=0, done=0.
- Level trigger: mask=8'h0F, pattern=8'h05, post=3, la_in=8'h00 for 10 cycles, then 8'hA5 -> pre_count=10, exactly 4 POST cycles, then state=3, done=1, sram_clk_en=0.
- Edge trigger: mask=8'h01, pattern=8'h01, edge=1, la_in bit0 already 1 at start -> no trigger. Bit0 0 then 1 -> trigger on the rising cycle.
- Zero mask, post=0: start -> one ARMED cycle, one POST cycle, DONE; post_count=1, pre_count=1.
- Abort race: assert start and abort together while IDLE -> stays IDLE. Abort during POST -> IDLE next cycle, done=0, counters held.
- LA_TRIG_TIMEOUT_EN build: timeout=20, no match -> POST at pre_count=20, timed_out=1. Rebuild without the macro -> stays ARMED indefinitely.
